lc3b_mem_responder: RTL and testbench

LC3B_MEM_RESPONDER -- requirements
Module: lc3b_mem_responder

---
 rtl/lc3b_mem_responder_pkg.sv | 13 +
 rtl/lc3b_mem_array.sv | 29 ++
 rtl/lc3b_mem_responder.sv | 141 ++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b memory types: word, write mask and responder FSM state.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_mem_array.sv
// Word-organised storage with combinational read and byte-lane write.
// Contents are deliberately not reset.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  lc3b_mem_wmask        be,
  input  logic [ADDR_BITS-1:0] waddr,
  input  lc3b_word             wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output lc3b_word             rdata
);

  lc3b_word mem [2**ADDR_BITS];

  assign rdata = mem[raddr];

  // Commit only the enabled byte lanes on the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[waddr][7:0]  <= wdata[7:0];
      if (be[1]) mem[waddr][15:8] <= wdata[15:8];
    end
  end

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: accepts a held read/write request, answers with a
// one-cycle mem_resp LATENCY cycles after acceptance.
// Optional: define LC3B_MEM_PROTO_CHECK_EN to add the sticky proto_err output.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output lc3b_word      mem_rdata,
`ifdef LC3B_MEM_PROTO_CHECK_EN
  output logic          proto_err,
`endif
  output logic          mem_resp
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  lc3b_memresp_state    state;
  logic [3:0]           cnt;
  lc3b_word             req_addr;
  lc3b_word             req_wdata;
  lc3b_mem_wmask        req_be;
  logic                 req_write;
  lc3b_word             arr_rdata;
  logic [ADDR_BITS-1:0] rd_idx;
  logic [ADDR_BITS-1:0] wr_idx;
  logic                 arr_we;
  logic                 unused_addr_bits;

  assign wr_idx = req_addr[ADDR_BITS:1];
  // With LATENCY=1 the read data is captured on the accepting edge, before
  // the address is latched, so IDLE looks up the live address instead.
  assign rd_idx = (state == IDLE) ? mem_address[ADDR_BITS:1] : wr_idx;
  // Write commits at the edge leaving RESP; reset clears state first.
  assign arr_we = (state == RESP) && req_write;
  assign unused_addr_bits = req_addr[0] ^ (|(req_addr >> (ADDR_BITS + 1)));

  lc3b_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (req_be),
    .waddr (wr_idx),
    .wdata (req_wdata),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  // Transaction FSM with registered mem_resp / mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      req_write <= 1'b0;
    end else begin
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            req_addr  <= mem_address;
            req_wdata <= mem_wdata;
            req_be    <= mem_byte_enable;
            req_write <= mem_write;
            if (LATENCY == 1) begin
              state     <= RESP;
              cnt       <= '0;
              mem_resp  <= 1'b1;
              mem_rdata <= mem_write ? '0 : arr_rdata;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (!(mem_read || mem_write)) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state     <= RESP;
            cnt       <= '0;
            mem_resp  <= 1'b1;
            mem_rdata <= req_write ? '0 : arr_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef LC3B_MEM_PROTO_CHECK_EN
  logic req_read;

  // Latch the raw read bit so op changes are visible to the checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_read <= 1'b0;
    end else if (state == IDLE && (mem_read || mem_write)) begin
      req_read <= mem_read;
    end
  end

  // Sticky flag: request fields must stay stable until the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if (state == WAIT || state == RESP) begin
      if ({mem_read, mem_write} != {req_read, req_write} ||
          mem_address     != req_addr  ||
          mem_byte_enable != req_be    ||
          mem_wdata       != req_wdata) begin
        proto_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed scoreboard bench for lc3b_mem_responder (LATENCY=2, ADDR_BITS=8).
module tb_lc3b_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [15:0] addr = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata;
  logic        resp;
`ifdef LC3B_MEM_PROTO_CHECK_EN
  logic        proto_err;
`endif

  lc3b_mem_responder #(
    .LATENCY   (LAT),
    .ADDR_BITS (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (be),
    .mem_address     (addr),
    .mem_wdata       (wdata),
    .mem_rdata       (rdata),
`ifdef LC3B_MEM_PROTO_CHECK_EN
    .proto_err       (proto_err),
`endif
    .mem_resp        (resp)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model [256];
  logic [15:0] exp_q [$];
  int unsigned last_resp_cyc = 0;

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [15:0] a);
    return int'(a[8:1]);
  endfunction

  // Drive a request in an IDLE cycle, score it and wait (bounded) for mem_resp.
  // Returns at the negedge inside RESP with the request still held.
  task automatic issue(input string tag, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [1:0] b, input logic [15:0] d);
    logic [15:0] cur;
    logic [15:0] expd;
    int          n;
    bit          got;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; addr = a; be = b; wdata = d;
    if (wr) begin
      cur = model[idx(a)];
      if (b[0]) cur[7:0]  = d[7:0];
      if (b[1]) cur[15:8] = d[15:8];
      model[idx(a)] = cur;
      exp_q.push_back(16'h0000);
    end else begin
      exp_q.push_back(model[idx(a)]);
    end
    @(posedge clk);
    n = 0; got = 1'b0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      if (resp === 1'b1) got = 1'b1;
      else check({tag, "_rdata_before_resp"}, rdata, 16'h0000);
    end
    check({tag, "_latency"}, 16'(n), 16'(LAT));
    expd = exp_q.pop_front();
    if (got) begin
      check({tag, "_rdata"}, rdata, expd);
      last_resp_cyc = cyc;
    end
  endtask

  task automatic drop();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int unsigned c1;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check("rst_resp", 16'(resp), 16'h0);
    check("rst_rdata", rdata, 16'h0000);
`ifdef LC3B_MEM_PROTO_CHECK_EN
    check("rst_proto_err", 16'(proto_err), 16'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write then read back
    issue("wr_beef", 1'b0, 1'b1, 16'h0010, 2'b11, 16'hBEEF); drop();
    issue("rd_beef", 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000); drop();

    // Byte enables
    issue("pre_1234", 1'b0, 1'b1, 16'h0020, 2'b11, 16'h1234); drop();
    issue("wr_be10", 1'b0, 1'b1, 16'h0020, 2'b10, 16'hAB00); drop();
    issue("rd_ab34", 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000); drop();
    issue("pre_1234b", 1'b0, 1'b1, 16'h0020, 2'b11, 16'h1234); drop();
    issue("wr_be00", 1'b0, 1'b1, 16'h0020, 2'b00, 16'hAB00); drop();
    issue("rd_1234", 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000); drop();
    issue("wr_be01", 1'b0, 1'b1, 16'h0020, 2'b01, 16'hCDEF); drop();
    issue("rd_12ef", 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000); drop();

    // Back-to-back reads, request held continuously
    issue("pre_0022", 1'b0, 1'b1, 16'h0022, 2'b11, 16'h0F0F); drop();
    issue("b2b_a", 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000);
    c1 = last_resp_cyc;
    issue("b2b_b", 1'b1, 1'b0, 16'h0022, 2'b00, 16'h0000); drop();
    check("b2b_spacing", 16'(last_resp_cyc - c1), 16'(LAT + 1));

    // Immediate read after write, back-to-back
    issue("raw_wr", 1'b0, 1'b1, 16'h0050, 2'b11, 16'h3C3C);
    issue("raw_rd", 1'b1, 1'b0, 16'h0050, 2'b00, 16'h0000); drop();

    // Aliasing above ADDR_BITS
    issue("alias_wr", 1'b0, 1'b1, 16'h0204, 2'b11, 16'h5A5A); drop();
    issue("alias_rd", 1'b1, 1'b0, 16'h0004, 2'b00, 16'h0000); drop();
    issue("alias_rd_hi", 1'b1, 1'b0, 16'hFE05, 2'b00, 16'h0000); drop();

    // Read and write together performs the write
    issue("both_op", 1'b1, 1'b1, 16'h0060, 2'b11, 16'h9876); drop();
    issue("both_rd", 1'b1, 1'b0, 16'h0060, 2'b00, 16'h0000); drop();

`ifdef LC3B_MEM_PROTO_CHECK_EN
    check("proto_clean", 16'(proto_err), 16'h0);
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 16'h0010; be = 2'b00; wdata = 16'h0000;
    @(posedge clk); #1;
    addr = 16'h0012;
    repeat (3) @(negedge clk);
    check("proto_set", 16'(proto_err), 16'h1);
    drop();
    repeat (3) @(negedge clk);
    check("proto_sticky", 16'(proto_err), 16'h1);
    rst_n = 1'b0;
    #2;
    check("proto_rst", 16'(proto_err), 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    // Requests dropped in WAIT abort the write
    issue("pre_4444", 1'b0, 1'b1, 16'h0040, 2'b11, 16'h4444); drop();
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 16'h0040; be = 2'b11; wdata = 16'hDEAD;
    @(posedge clk); #1;
    mem_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_resp", 16'(resp), 16'h0);
    end
    issue("abort_rd", 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000); drop();

    // Reset in WAIT aborts the write
    issue("pre_7777", 1'b0, 1'b1, 16'h0030, 2'b11, 16'h7777); drop();
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 16'h0030; be = 2'b11; wdata = 16'h1111;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_wait_resp", 16'(resp), 16'h0);
    check("rst_wait_rdata", rdata, 16'h0000);
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_wait_no_resp", 16'(resp), 16'h0);
    end
    issue("rst_rd", 1'b1, 1'b0, 16'h0030, 2'b00, 16'h0000); drop();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
